// File: rtl/cpu_controller.sv
// Instruction sequencer for the 8-bit RISC CPU: fetches 1- or 2-byte instructions,
// holds pc/ir/operand address and drives Moore strobes that steer data into and out of the ALU.
module cpu_controller #(
    parameter logic [7:0] PC_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rom_data,
    output logic [7:0] rom_addr,
    output logic       rom_rd,
    output logic [7:0] ram_addr,
    output logic       ram_rd,
    output logic       ram_wr,
    output logic [4:0] reg_addr,
    output logic       reg_rd,
    output logic       reg_wr,
    output logic [2:0] alu_op,
    output logic [1:0] data_sel,
    output logic       acc_ld,
    output logic       halted,
    output logic [7:0] pc
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;

    localparam logic [2:0] OP_LDO = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STO = 3'b011;
    localparam logic [2:0] OP_PRE = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_LDM = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] SEL_ROM = 2'b00;
    localparam logic [1:0] SEL_RAM = 2'b01;
    localparam logic [1:0] SEL_REG = 2'b10;

    logic [2:0] state;
    logic [7:0] ir;
    logic [7:0] addr_reg;
    logic [2:0] op;
    logic       two_byte;

    assign op       = ir[7:5];
    assign two_byte = (op == OP_LDO) || (op == OP_LDA) || (op == OP_STO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= PC_RST;
            ir       <= 8'h00;
            addr_reg <= 8'h00;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    ir    <= rom_data;
                    pc    <= pc + 8'd1;
                    state <= DECODE;
                end
                DECODE: begin
                    // Operand byte is fetched here so 2-byte instructions cost no extra cycle
                    if (two_byte) begin
                        addr_reg <= rom_data;
                        pc       <= pc + 8'd1;
                        state    <= EXEC;
                    end else if (op == OP_HLT) begin
                        state <= HALT;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC:    state <= FETCH;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_addr = addr_reg;
    assign reg_addr = ir[4:0];
    assign alu_op   = op;

    always_comb begin
        rom_addr = pc;
        rom_rd   = 1'b0;
        ram_rd   = 1'b0;
        ram_wr   = 1'b0;
        reg_rd   = 1'b0;
        reg_wr   = 1'b0;
        data_sel = SEL_ROM;
        acc_ld   = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH:  rom_rd = 1'b1;
            DECODE: rom_rd = two_byte;
            EXEC: begin
                case (op)
                    OP_LDO: begin
                        rom_rd   = 1'b1;
                        rom_addr = addr_reg;
                        data_sel = SEL_ROM;
                        acc_ld   = 1'b1;
                    end
                    OP_LDA: begin
                        ram_rd   = 1'b1;
                        data_sel = SEL_RAM;
                        acc_ld   = 1'b1;
                    end
                    OP_STO: ram_wr = 1'b1;
                    OP_PRE, OP_ADD: begin
                        reg_rd   = 1'b1;
                        data_sel = SEL_REG;
                        acc_ld   = 1'b1;
                    end
                    OP_LDM:  reg_wr = 1'b1;
                    default: ;
                endcase
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-cycle expected output vectors are queued
// alongside the stimulus and popped at each falling edge against the DUT outputs.
module tb_cpu_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [7:0] rom_a [256];
    logic [7:0] rom_b [256];

    logic [7:0] rom_data_a, rom_addr_a, ram_addr_a, pc_a;
    logic       rom_rd_a, ram_rd_a, ram_wr_a, reg_rd_a, reg_wr_a, acc_ld_a, halted_a;
    logic [4:0] reg_addr_a;
    logic [2:0] alu_op_a;
    logic [1:0] data_sel_a;

    logic [7:0] rom_data_b, rom_addr_b, ram_addr_b, pc_b;
    logic       rom_rd_b, ram_rd_b, ram_wr_b, reg_rd_b, reg_wr_b, acc_ld_b, halted_b;
    logic [4:0] reg_addr_b;
    logic [2:0] alu_op_b;
    logic [1:0] data_sel_b;

    assign rom_data_a = rom_a[rom_addr_a];
    assign rom_data_b = rom_b[rom_addr_b];

    cpu_controller #(.PC_RST(8'h00)) dut_a (
        .clk(clk), .rst(rst_a), .rom_data(rom_data_a), .rom_addr(rom_addr_a), .rom_rd(rom_rd_a),
        .ram_addr(ram_addr_a), .ram_rd(ram_rd_a), .ram_wr(ram_wr_a), .reg_addr(reg_addr_a),
        .reg_rd(reg_rd_a), .reg_wr(reg_wr_a), .alu_op(alu_op_a), .data_sel(data_sel_a),
        .acc_ld(acc_ld_a), .halted(halted_a), .pc(pc_a)
    );

    cpu_controller #(.PC_RST(8'hFF)) dut_b (
        .clk(clk), .rst(rst_b), .rom_data(rom_data_b), .rom_addr(rom_addr_b), .rom_rd(rom_rd_b),
        .ram_addr(ram_addr_b), .ram_rd(ram_rd_b), .ram_wr(ram_wr_b), .reg_addr(reg_addr_b),
        .reg_rd(reg_rd_b), .reg_wr(reg_wr_b), .alu_op(alu_op_b), .data_sel(data_sel_b),
        .acc_ld(acc_ld_b), .halted(halted_b), .pc(pc_b)
    );

    // Strobe field order: {rom_rd, ram_rd, ram_wr, reg_rd, reg_wr, acc_ld, halted}
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_ROM   = 7'b1000000;
    localparam logic [6:0] S_LDO   = 7'b1000010;
    localparam logic [6:0] S_LDA   = 7'b0100010;
    localparam logic [6:0] S_STO   = 7'b0010000;
    localparam logic [6:0] S_REGRD = 7'b0001010;
    localparam logic [6:0] S_REGWR = 7'b0000100;
    localparam logic [6:0] S_HALT  = 7'b0000001;

    // Addresses only matter while their strobe is active, so idle addresses are zeroed
    function automatic logic [40:0] pack_obs(
        input logic rom_rd, input logic [7:0] rom_addr, input logic ram_rd, input logic ram_wr,
        input logic [7:0] ram_addr, input logic reg_rd, input logic reg_wr, input logic [4:0] reg_addr,
        input logic acc_ld, input logic [1:0] data_sel, input logic [2:0] alu_op, input logic halted,
        input logic [7:0] pc);
        logic [7:0] ra, ma;
        logic [4:0] ga;
        ra = rom_rd ? rom_addr : 8'h00;
        ma = (ram_rd | ram_wr) ? ram_addr : 8'h00;
        ga = (reg_rd | reg_wr) ? reg_addr : 5'h00;
        return {rom_rd, ram_rd, ram_wr, reg_rd, reg_wr, acc_ld, halted, ra, ma, ga, data_sel, alu_op, pc};
    endfunction

    logic [40:0] obs_a, obs_b;
    assign obs_a = pack_obs(rom_rd_a, rom_addr_a, ram_rd_a, ram_wr_a, ram_addr_a, reg_rd_a, reg_wr_a,
                            reg_addr_a, acc_ld_a, data_sel_a, alu_op_a, halted_a, pc_a);
    assign obs_b = pack_obs(rom_rd_b, rom_addr_b, ram_rd_b, ram_wr_b, ram_addr_b, reg_rd_b, reg_wr_b,
                            reg_addr_b, acc_ld_b, data_sel_b, alu_op_b, halted_b, pc_b);

    int ram_wr_cnt = 0;
    int reg_wr_cnt = 0;
    always @(posedge clk) begin
        if (ram_wr_a) ram_wr_cnt <= ram_wr_cnt + 1;
        if (reg_wr_a) reg_wr_cnt <= reg_wr_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [40:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic expect_v(input logic [6:0] s, input logic [7:0] ra, input logic [7:0] ma,
                            input logic [4:0] ga, input logic [1:0] ds, input logic [2:0] op,
                            input logic [7:0] pcv);
        exp_q.push_back({s, ra, ma, ga, ds, op, pcv});
    endtask

    task automatic compare_one(input bit sel, input string tag);
        logic [40:0] w;
        logic [40:0] got;
        got = sel ? obs_b : obs_a;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got %h with no expected entry queued", tag, got);
        end else begin
            w = exp_q.pop_front();
            check(tag, 64'(got), 64'(w));
        end
    endtask

    task automatic run(input bit sel, input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_one(sel, $sformatf("%s%0d", name, i));
        end
    endtask

    task automatic do_reset(input bit sel, input logic [7:0] pc_rst);
        @(negedge clk);
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        for (int i = 0; i < 3; i++) expect_v(S_NONE, 8'h00, 8'h00, 5'h00, 2'b00, 3'b000, pc_rst);
        run(sel, sel ? "rst_b" : "rst_a", 3);
        @(posedge clk);
        #1;
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_ram, base_reg;
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 8'h00;
            rom_b[i] = 8'h00;
        end
        // LDO 0x40; ADD r3; STO 0x7F; LDM r5; HLT
        rom_a[0] = 8'h20; rom_a[1] = 8'h40; rom_a[2] = 8'hA3;
        rom_a[3] = 8'h60; rom_a[4] = 8'h7F; rom_a[5] = 8'hC5; rom_a[6] = 8'hE0;
        rom_a[8'h40] = 8'h99;

        do_reset(1'b0, 8'h00);
        base_ram = ram_wr_cnt;
        base_reg = reg_wr_cnt;
        expect_v(S_NONE,  8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'h00);
        expect_v(S_ROM,   8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'h00);
        expect_v(S_ROM,   8'h01, 8'h00, 5'd0, 2'b00, 3'd1, 8'h01);
        expect_v(S_LDO,   8'h40, 8'h00, 5'd0, 2'b00, 3'd1, 8'h02);
        expect_v(S_ROM,   8'h02, 8'h00, 5'd0, 2'b00, 3'd1, 8'h02);
        expect_v(S_NONE,  8'h00, 8'h00, 5'd0, 2'b00, 3'd5, 8'h03);
        expect_v(S_REGRD, 8'h00, 8'h00, 5'd3, 2'b10, 3'd5, 8'h03);
        expect_v(S_ROM,   8'h03, 8'h00, 5'd0, 2'b00, 3'd5, 8'h03);
        expect_v(S_ROM,   8'h04, 8'h00, 5'd0, 2'b00, 3'd3, 8'h04);
        expect_v(S_STO,   8'h00, 8'h7F, 5'd0, 2'b00, 3'd3, 8'h05);
        expect_v(S_ROM,   8'h05, 8'h00, 5'd0, 2'b00, 3'd3, 8'h05);
        expect_v(S_NONE,  8'h00, 8'h00, 5'd0, 2'b00, 3'd6, 8'h06);
        expect_v(S_REGWR, 8'h00, 8'h00, 5'd5, 2'b00, 3'd6, 8'h06);
        expect_v(S_ROM,   8'h06, 8'h00, 5'd0, 2'b00, 3'd6, 8'h06);
        expect_v(S_NONE,  8'h00, 8'h00, 5'd0, 2'b00, 3'd7, 8'h07);
        for (int i = 0; i < 20; i++) expect_v(S_HALT, 8'h00, 8'h00, 5'd0, 2'b00, 3'd7, 8'h07);
        run(1'b0, "prog", 35);
        check("sto_wr_pulses", 64'(ram_wr_cnt - base_ram), 64'd1);
        check("ldm_wr_pulses", 64'(reg_wr_cnt - base_reg), 64'd1);

        // Reset out of HALT, then abort a STO during its execute cycle
        rom_a[0] = 8'h60; rom_a[1] = 8'h33;
        do_reset(1'b0, 8'h00);
        base_ram = ram_wr_cnt;
        expect_v(S_NONE,  8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'h00);
        expect_v(S_ROM,   8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'h00);
        expect_v(S_ROM,   8'h01, 8'h00, 5'd0, 2'b00, 3'd3, 8'h01);
        expect_v(S_STO,   8'h00, 8'h33, 5'd0, 2'b00, 3'd3, 8'h02);
        run(1'b0, "abort", 4);
        #1;
        rst_a = 1'b0;
        #1;
        expect_v(S_NONE, 8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'h00);
        compare_one(1'b0, "abort_rst_now");
        @(posedge clk);
        #1;
        check("abort_no_write", 64'(ram_wr_cnt - base_ram), 64'd0);
        rst_a = 1'b1;
        expect_v(S_NONE, 8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'h00);
        expect_v(S_ROM,  8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'h00);
        run(1'b0, "restart", 2);

        // LDA at 0xFF: operand comes from 0x00 after pc wraps
        rom_b[8'hFF] = 8'h40; rom_b[8'h00] = 8'h12;
        do_reset(1'b1, 8'hFF);
        expect_v(S_NONE, 8'h00, 8'h00, 5'd0, 2'b00, 3'd0, 8'hFF);
        expect_v(S_ROM,  8'hFF, 8'h00, 5'd0, 2'b00, 3'd0, 8'hFF);
        expect_v(S_ROM,  8'h00, 8'h00, 5'd0, 2'b00, 3'd2, 8'h00);
        expect_v(S_LDA,  8'h00, 8'h12, 5'd0, 2'b01, 3'd2, 8'h01);
        expect_v(S_ROM,  8'h01, 8'h00, 5'd0, 2'b00, 3'd2, 8'h01);
        run(1'b1, "wrap", 5);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction sequencer for the 8-bit RISC CPU. It holds the program counter and instruction register, fetches 1- or 2-byte instructions from ROM, and drives the 3-bit opcode into the ALU's op input. Per instruction it generates the strobes that route ROM, RAM or register-file data to the ALU and latch the ALU result into the accumulator, RAM or register file. It sits directly upstream of the ALU.

Parameters:
PC_RST, 8'h00, program counter value after reset.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
rom_data  in  8  ROM read data. ROM read is combinational: valid in the same cycle as rom_addr.
rom_addr  out  8  ROM address: pc in fetch/operand cycles, addr_reg in LDO execute.
rom_rd  out  1  ROM read strobe.
ram_addr  out  8  RAM address, equal to addr_reg.
ram_rd  out  1  RAM read strobe. RAM read is combinational.
ram_wr  out  1  RAM write strobe; RAM writes the accumulator on the clock edge.
reg_addr  out  5  register-file index, equal to ir[4:0].
reg_rd  out  1  register-file read strobe.
reg_wr  out  1  register-file write strobe; writes the accumulator.
alu_op  out  3  opcode to the ALU, equal to ir[7:5].
data_sel  out  2  alu_in source mux: 00 ROM, 01 RAM, 10 register file, 11 unused.
acc_ld  out  1  accumulator loads the ALU output on this edge.
halted  out  1  high while in HALT.
pc  out  8  current program counter.

Behaviour:
- Instruction byte format: op[7:5], reg[4:0].
- Opcodes: NOP=000, LDO=001, LDA=010, STO=011, PRE=100, ADD=101, LDM=110, HLT=111.
- LDO, LDA and STO are two bytes; the second byte is an 8-bit address. All other opcodes are one byte.
- Registers: state, pc[7:0], ir[7:0], addr_reg[7:0].
- All outputs are combinational from state, ir and addr_reg (Moore). Any strobe not listed for a state is 0.
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=PC_RST, ir=8'h00, addr_reg=8'h00.
  - All strobes 0, alu_op=000, data_sel=00, halted=0.
  - Reset asserted mid-instruction aborts it immediately. No partial write completes after the reset edge.
- IDLE: all strobes 0. Go to FETCH next cycle.
- FETCH:
  - rom_rd=1, rom_addr=pc.
  - On the edge: ir<=rom_data, pc<=pc+1, go to DECODE.
- DECODE:
  - If ir op is LDO, LDA or STO: rom_rd=1, rom_addr=pc. On the edge: addr_reg<=rom_data, pc<=pc+1, go to EXEC.
  - If ir op is HLT: go to HALT; pc unchanged.
  - Otherwise: no strobes, go to EXEC.
- EXEC (always returns to FETCH; alu_op=ir[7:5]):
  - NOP: no strobes.
  - LDO: rom_rd=1, rom_addr=addr_reg, data_sel=00, acc_ld=1.
  - LDA: ram_rd=1, data_sel=01, acc_ld=1.
  - STO: ram_wr=1.
  - PRE: reg_rd=1, data_sel=10, acc_ld=1.
  - ADD: reg_rd=1, data_sel=10, acc_ld=1.
  - LDM: reg_wr=1.
- HALT: halted=1, no strobes. Leaves only via reset.
- Cycle counts:
  - 1-byte non-HLT instruction: 3 cycles.
  - 2-byte instruction: 3 cycles (operand fetched in DECODE).
  - HLT: 2 cycles to reach HALT.
- pc increments modulo 256: 8'hFF+1 = 8'h00.
- A 2-byte instruction at 8'hFF fetches its operand from 8'h00.
- ram_wr, reg_wr and acc_ld are never high in the same cycle.
- rom_rd and ram_rd are never high in the same cycle.

Test Plan:
1. Reset: hold rst=0 for 3 cycles, release -> 1 IDLE cycle with all strobes 0, then FETCH with rom_addr=8'h00 and rom_rd=1.
2. Program 8'h20,8'h40 (LDO 0x40) then 8'hA3 (ADD r3) -> LDO EXEC cycle: rom_addr=8'h40, data_sel=00, acc_ld=1, alu_op=001. ADD EXEC cycle: reg_addr=3, data_sel=10, acc_ld=1, alu_op=101. pc=8'h03 after ADD completes.
3. STO 8'h7F (8'h60,8'h7F) -> exactly one ram_wr pulse with ram_addr=8'h7F, alu_op=011, acc_ld=0. LDM r5 (8'hC5) -> one reg_wr pulse with reg_addr=5.
4. Wrap: force pc to 8'hFF via PC_RST=8'hFF, ROM[FF]=8'h40, ROM[00]=8'h12 -> LDA uses ram_addr=8'h12. pc=8'h01 afterwards.
5. HLT (8'hE0) -> halted=1 two cycles after FETCH. pc stays frozen and no strobes over 20 cycles. rst pulse returns to IDLE with halted=0.
6. Assert rst during the EXEC cycle of STO -> ram_wr drops to 0 immediately with no write, and fetch restarts at PC_RST.
